// File: rtl/aes_dec_round_ctrl.sv
// Sequencer for the AES-128 inverse cipher: starts key expansion, then steps one
// ciphertext block at a time through round-key indices 0..10 with datapath strobes.
module aes_dec_round_ctrl #(
    parameter int unsigned KEYEXP_CYCLES = 12,
    parameter int unsigned KEY_LAT       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_accept,
    output logic       key_load,
    output logic       key_ready,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] round_idx,
    output logic       state_en,
    output logic       sel_input,
    output logic       sel_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);

    localparam int unsigned CNT_W   = $clog2(KEYEXP_CYCLES + 1);
    localparam int unsigned WCNT_W  = $clog2(KEY_LAT + 1);
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned LAST_RD = 10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_READY  = 3'd2,
        S_RWAIT  = 3'd3,
        S_REXEC  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [IDX_W-1:0]   round_idx_q, round_idx_d;
    logic               key_load_q, key_load_d;
    logic               key_ready_q, key_ready_d;
    logic               key_accept_q, key_accept_d;
    logic               state_en_q, state_en_d;
    logic               sel_input_q, sel_input_d;
    logic               sel_last_q, sel_last_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               key_fire;
    logic               in_fire;

    // A key change in READY takes priority over a block offered in the same cycle.
    assign in_ready = (state_q == S_READY) & ~key_valid;
    assign key_fire = key_valid & key_accept_q;
    assign in_fire  = in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        round_idx_d = round_idx_q;
        key_ready_d = key_ready_q;
        key_load_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (key_fire) begin
                    key_load_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_KEYEXP;
                end
            end
            S_KEYEXP: begin
                if (cnt_q == CNT_W'(KEYEXP_CYCLES - 1)) begin
                    cnt_d       = '0;
                    key_ready_d = 1'b1;
                    state_d     = S_READY;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_READY: begin
                if (key_fire) begin
                    key_ready_d = 1'b0;
                    key_load_d  = 1'b1;
                    cnt_d       = '0;
                    state_d     = S_KEYEXP;
                end else if (in_fire) begin
                    round_idx_d = '0;
                    wcnt_d      = '0;
                    state_d     = S_RWAIT;
                end
            end
            S_RWAIT: begin
                // Give the key store KEY_LAT cycles to settle on the new index.
                if (wcnt_q == WCNT_W'(KEY_LAT - 1)) begin
                    wcnt_d  = '0;
                    state_d = S_REXEC;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            S_REXEC: begin
                if (round_idx_q == IDX_W'(LAST_RD)) begin
                    state_d = S_DONE;
                end else begin
                    round_idx_d = round_idx_q + IDX_W'(1);
                    wcnt_d      = '0;
                    state_d     = S_RWAIT;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    round_idx_d = '0;
                    state_d     = S_READY;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered outputs are decoded from the next state so they align with state_q.
        key_accept_d = (state_d == S_IDLE) || (state_d == S_READY);
        busy_d       = ~key_accept_d;
        state_en_d   = (state_d == S_REXEC);
        sel_input_d  = state_en_d && (round_idx_d == IDX_W'(0));
        sel_last_d   = state_en_d && (round_idx_d == IDX_W'(LAST_RD));
        out_valid_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            round_idx_q  <= '0;
            key_load_q   <= 1'b0;
            key_ready_q  <= 1'b0;
            key_accept_q <= 1'b0;
            state_en_q   <= 1'b0;
            sel_input_q  <= 1'b0;
            sel_last_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            round_idx_q  <= round_idx_d;
            key_load_q   <= key_load_d;
            key_ready_q  <= key_ready_d;
            key_accept_q <= key_accept_d;
            state_en_q   <= state_en_d;
            sel_input_q  <= sel_input_d;
            sel_last_q   <= sel_last_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign key_accept = key_accept_q;
    assign key_load   = key_load_q;
    assign key_ready  = key_ready_q;
    assign round_idx  = round_idx_q;
    assign state_en   = state_en_q;
    assign sel_input  = sel_input_q;
    assign sel_last   = sel_last_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Scoreboard bench for aes_dec_round_ctrl: handshakes seen on the inputs push expected
// round strobes and completion times; a negedge monitor compares every output each cycle.
module tb_aes_dec_round_ctrl;

    localparam int unsigned KL = 1;
    localparam int unsigned KE = 12;
    localparam int          NROUNDS = 11;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid, key_accept, key_load, key_ready;
    logic       in_valid, in_ready;
    logic [3:0] round_idx;
    logic       state_en, sel_input, sel_last, out_valid, out_ready, busy;

    aes_dec_round_ctrl #(.KEYEXP_CYCLES(KE), .KEY_LAT(KL)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_accept(key_accept), .key_load(key_load),
        .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready),
        .round_idx(round_idx), .state_en(state_en), .sel_input(sel_input),
        .sel_last(sel_last), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    // Reference model: round strobes due at fixed offsets after the accept, one block in flight.
    typedef struct { int c; int r; } rnd_t;
    rnd_t rq[$];
    int   dq[$];
    bit   m_kready, m_expanding, m_skip;
    int   load_at, ready_at;

    always @(negedge clk) begin
        bit   blk, e_acc, e_in, e_ov, e_se;
        rnd_t it;
        if (rst) begin
            rq.delete();
            dq.delete();
            m_kready    = 1'b0;
            m_expanding = 1'b0;
            m_skip      = 1'b1;
            load_at     = -1;
            ready_at    = -1;
        end else begin
            if (cyc == ready_at) begin
                m_expanding = 1'b0;
                m_kready    = 1'b1;
            end
            blk   = dq.size() > 0;
            e_acc = !m_skip && !m_expanding && !blk;
            e_in  = e_acc && m_kready && !key_valid;
            e_ov  = blk && (cyc >= dq[0]);
            e_se  = (rq.size() > 0) && (rq[0].c == cyc);

            chk("key_accept", key_accept, e_acc);
            chk("in_ready", in_ready, e_in);
            chk("key_load", key_load, cyc == load_at);
            chk("key_ready", key_ready, m_kready);
            chk("busy", busy, m_expanding || blk);
            chk("out_valid", out_valid, e_ov);
            chk("state_en", state_en, e_se);
            chk("round_idx_range", round_idx > 4'd10, 0);
            if (e_se) begin
                chk("round_idx", round_idx, rq[0].r);
                chk("sel_input", sel_input, rq[0].r == 0);
                chk("sel_last", sel_last, rq[0].r == NROUNDS - 1);
                void'(rq.pop_front());
            end else begin
                chk("sel_idle", {sel_input, sel_last}, 0);
            end

            if (key_valid && e_acc) begin
                m_expanding = 1'b1;
                m_kready    = 1'b0;
                load_at     = cyc + 1;
                ready_at    = cyc + KE + 1;
            end else if (in_valid && e_in) begin
                for (int r = 0; r < NROUNDS; r++) begin
                    it.c = cyc + (r + 1) * (KL + 1);
                    it.r = r;
                    rq.push_back(it);
                end
                dq.push_back(cyc + NROUNDS * (KL + 1) + 1);
            end
            if (e_ov && out_ready) void'(dq.pop_front());
            m_skip = 1'b0;
        end
    end

    function automatic bit cond(input int which);
        case (which)
            0:       return key_ready;
            1:       return out_valid;
            default: return state_en && (round_idx == 4'd5);
        endcase
    endfunction

    task automatic wait_until(input int which, input int budget);
        int n = 0;
        while (!cond(which) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        chk($sformatf("wait_%0d", which), cond(which), 1);
    endtask

    task automatic send_block();
        int n = 0;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_key();
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_key_accept"}, key_accept, 0);
        chk({tag, "_key_load"}, key_load, 0);
        chk({tag, "_key_ready"}, key_ready, 0);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_round_idx"}, round_idx, 0);
        chk({tag, "_state_en"}, state_en, 0);
        chk({tag, "_sel"}, {sel_input, sel_last}, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst       = 1'b1;
        key_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Key expansion, then one block with the consumer always ready.
        pulse_key();
        wait_until(0, 40);
        send_block();
        wait_until(1, 100);
        @(posedge clk); #1;

        // Back-pressure: consumer stalls five cycles in DONE.
        out_ready = 1'b0;
        send_block();
        wait_until(1, 100);
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Key and block offered together in READY: the key wins.
        wait_until(0, 40);
        key_valid = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        in_valid  = 1'b0;
        wait_until(0, 40);

        // Asynchronous reset in the middle of round 5.
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_until(2, 100);
        #2;
        rst = 1'b1;
        #1;
        check_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        in_valid = 1'b0;
        pulse_key();
        wait_until(0, 40);

        // Random traffic on all three handshakes.
        repeat (3000) begin
            key_valid = ($urandom_range(0, 39) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("rounds_drained", rq.size(), 0);
        chk("blocks_drained", dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
